// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle control unit: state encodings,
// opcode/funct constants, ALU/RegDst/MemtoReg codes and instruction classes.
package mc_defs;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;

  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [3:0] {
    CL_RTYPE, CL_ORI, CL_LUI, CL_LW, CL_SW, CL_BEQ, CL_J, CL_JAL, CL_ILL
  } iclass_e;

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath/memory bundle. master = control unit, slave = datapath.
interface mc_control_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             PCwrt;
  logic             branch;
  logic             jump;
  logic             IRwrt;
  logic             RegWrite;
  logic [1:0]       RegDst;
  logic [1:0]       MemtoReg;
  logic             ALUSrc;
  logic             ExtOp;
  logic [2:0]       ALUop;
  logic             mem_rd;
  logic             mem_wr;
  logic             err;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output PCwrt, branch, jump, IRwrt, RegWrite, RegDst, MemtoReg,
           ALUSrc, ExtOp, ALUop, mem_rd, mem_wr, err, state, instr_cnt
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  PCwrt, branch, jump, IRwrt, RegWrite, RegDst, MemtoReg,
           ALUSrc, ExtOp, ALUop, mem_rd, mem_wr, err, state, instr_cnt
  );
endinterface

// File: rtl/mc_control_decode.sv
// Combinational instruction decoder: opcode/funct to instruction class,
// static datapath controls and an illegal-instruction flag.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output iclass_e    iclass_o,
  output logic [2:0] alu_op_o,
  output logic       alu_src_o,
  output logic       ext_op_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       illegal_o
);

  always_comb begin
    iclass_o     = CL_ILL;
    alu_op_o     = ALU_ADD;
    alu_src_o    = 1'b0;
    ext_op_o     = 1'b0;
    reg_dst_o    = RD_RT;
    mem_to_reg_o = WB_ALU;
    case (opcode_i)
      OP_RTYPE: begin
        iclass_o  = CL_RTYPE;
        reg_dst_o = RD_RD;
        case (funct_i)
          FN_ADDU: alu_op_o = ALU_ADD;
          FN_SUBU: alu_op_o = ALU_SUB;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          FN_SLT:  alu_op_o = ALU_SLT;
          default: iclass_o = CL_ILL;
        endcase
      end
      OP_ORI: begin
        iclass_o  = CL_ORI;
        alu_op_o  = ALU_OR;
        alu_src_o = 1'b1;
      end
      OP_LUI: begin
        iclass_o  = CL_LUI;
        alu_op_o  = ALU_LUI;
        alu_src_o = 1'b1;
      end
      OP_LW: begin
        iclass_o     = CL_LW;
        alu_src_o    = 1'b1;
        ext_op_o     = 1'b1;
        mem_to_reg_o = WB_MEM;
      end
      OP_SW: begin
        iclass_o  = CL_SW;
        alu_src_o = 1'b1;
        ext_op_o  = 1'b1;
      end
      OP_BEQ: begin
        iclass_o = CL_BEQ;
        alu_op_o = ALU_SUB;
        ext_op_o = 1'b1;
      end
      OP_J:   iclass_o = CL_J;
      OP_JAL: begin
        iclass_o     = CL_JAL;
        reg_dst_o    = RD_R31;
        mem_to_reg_o = WB_PC4;
      end
      default: iclass_o = CL_ILL;
    endcase
    illegal_o = (iclass_o == CL_ILL);
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM: IF/ID/EXE/MEM/WB sequencing, memory wait timeout
// trap into a sticky ERR state, and a retired-instruction counter.
module mc_control
  import mc_defs::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);

  localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]    instr_cnt_q;

  iclass_e     iclass;
  logic [2:0]  dec_alu_op;
  logic        dec_alu_src, dec_ext_op, dec_illegal;
  logic [1:0]  dec_reg_dst, dec_mem_to_reg;

  logic        pc_wrt, branch, jump, ir_wrt, reg_write, alu_src, ext_op, mem_rd, mem_wr;
  logic [1:0]  reg_dst, mem_to_reg;
  logic [2:0]  alu_op;
  logic        wait_expired;

  mc_decode u_decode (
    .opcode_i     (bus.opcode),
    .funct_i      (bus.funct),
    .iclass_o     (iclass),
    .alu_op_o     (dec_alu_op),
    .alu_src_o    (dec_alu_src),
    .ext_op_o     (dec_ext_op),
    .reg_dst_o    (dec_reg_dst),
    .mem_to_reg_o (dec_mem_to_reg),
    .illegal_o    (dec_illegal)
  );

  // Expiry is checked on the cycle that would be the TIMEOUT-th wait.
  assign wait_expired = (TIMEOUT != 0) && (wcnt_q == WCNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    wcnt_d     = '0;
    pc_wrt     = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    ir_wrt     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = WB_ALU;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    alu_op     = ALU_ADD;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    case (state_q)
      S_IF: begin
        mem_rd = 1'b1;
        if (bus.mem_ready) begin
          ir_wrt  = 1'b1;
          state_d = S_ID;
        end else if (wait_expired) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_ID: begin
        if (dec_illegal) begin
          state_d = S_ERR;
        end else if (iclass == CL_J || iclass == CL_JAL) begin
          jump    = 1'b1;
          pc_wrt  = 1'b1;
          state_d = S_IF;
          if (iclass == CL_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = dec_reg_dst;
            mem_to_reg = dec_mem_to_reg;
          end
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        ext_op  = dec_ext_op;
        case (iclass)
          CL_RTYPE, CL_ORI, CL_LUI: state_d = S_WB;
          CL_LW, CL_SW:             state_d = S_MEM;
          CL_BEQ: begin
            branch  = bus.zero;
            pc_wrt  = 1'b1;
            state_d = S_IF;
          end
          default:                  state_d = S_ERR;
        endcase
      end
      S_MEM: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        ext_op  = dec_ext_op;
        mem_rd  = (iclass == CL_LW);
        mem_wr  = (iclass == CL_SW);
        if (bus.mem_ready) begin
          if (iclass == CL_LW) begin
            state_d = S_WB;
          end else if (iclass == CL_SW) begin
            pc_wrt  = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_ERR;
          end
        end else if (wait_expired) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_WB: begin
        alu_op     = dec_alu_op;
        alu_src    = dec_alu_src;
        ext_op     = dec_ext_op;
        reg_dst    = dec_reg_dst;
        mem_to_reg = dec_mem_to_reg;
        reg_write  = 1'b1;
        pc_wrt     = 1'b1;
        state_d    = S_IF;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    // Reset aborts the in-flight instruction: nothing may retire or touch memory.
    if (reset) begin
      pc_wrt     = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      ir_wrt     = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = RD_RT;
      mem_to_reg = WB_ALU;
      alu_src    = 1'b0;
      ext_op     = 1'b0;
      alu_op     = ALU_ADD;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IF;
      wcnt_q      <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (pc_wrt) instr_cnt_q <= instr_cnt_q + 1'b1;
    end
  end

  assign bus.PCwrt     = pc_wrt;
  assign bus.branch    = branch;
  assign bus.jump      = jump;
  assign bus.IRwrt     = ir_wrt;
  assign bus.RegWrite  = reg_write;
  assign bus.RegDst    = reg_dst;
  assign bus.MemtoReg  = mem_to_reg;
  assign bus.ALUSrc    = alu_src;
  assign bus.ExtOp     = ext_op;
  assign bus.ALUop     = alu_op;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.err       = (state_q == S_ERR);
  assign bus.state     = state_q;
  assign bus.instr_cnt = instr_cnt_q;

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle control FSM for the single-issue MIPS-subset core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives PCwrt, branch and jump into the next-PC/PC register block.
- Issues IR, register-file, ALU and memory strobes, with a ready handshake to memory and a wait-timeout error trap.

Parameters:
- TIMEOUT, 16: consecutive not-ready wait cycles in IF or MEM before trapping to ERR. 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag; valid in EXE.
- mem_ready  in  1  memory completes the current read/write this cycle.
- PCwrt  out  1  PC load enable to the next-PC block.
- branch  out  1  take branch target (beq and zero).
- jump  out  1  take jump target.
- IRwrt  out  1  instruction register load.
- RegWrite  out  1  register-file write enable.
- RegDst  out  2  destination select: 0 = rt, 1 = rd, 2 = r31.
- MemtoReg  out  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4.
- ALUSrc  out  1  0 = rt, 1 = extended immediate.
- ExtOp  out  1  0 = zero-extend, 1 = sign-extend.
- ALUop  out  3  ALU operation: 0 add, 1 sub, 2 or, 3 and, 4 slt, 5 lui.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- err  out  1  trapped in ERR.
- state  out  3  current state, for debug.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: clk is the single clock. reset is synchronous, active-high. A reset-asserted posedge gives state=IF, wcnt=0, instr_cnt=0, err=0.
- Strobes during reset: while reset=1, PCwrt, IRwrt, RegWrite, mem_rd, mem_wr, branch and jump are forced to 0. Mux selects are 0.
- Reset mid-instruction aborts it; no PCwrt or RegWrite is issued.
- Output timing: all strobes are combinational from the registered state plus opcode/funct/zero/mem_ready. Each strobe is held for the full cycle, so downstream negedge sampling sees stable values.
- Supported opcodes:
  - R-type 0x00, with funct 0x21 addu, 0x23 subu, 0x24 and, 0x25 or, 0x2a slt.
  - ori 0x0d, lui 0x0f, lw 0x23, sw 0x2b, beq 0x04, j 0x02, jal 0x03.
  - Any other opcode, or any unlisted funct, is illegal.
- State encoding: IF=0, ID=1, EXE=2, MEM=3, WB=4, ERR=7.
- IF:
  - mem_rd=1.
  - If mem_ready=1: IRwrt=1, go to ID.
  - Else stay, wcnt++.
- ID:
  - Illegal instruction: go to ERR.
  - j: jump=1, PCwrt=1, go to IF.
  - jal: jump=1, PCwrt=1, RegWrite=1, RegDst=2, MemtoReg=2, go to IF.
  - All others: go to EXE.
- EXE:
  - R-type, ori, lui: ALU controls asserted, go to WB.
  - lw, sw: ALUop=add, ALUSrc=1, ExtOp=1, go to MEM.
  - beq: ALUop=sub, branch=zero, PCwrt=1, go to IF.
- MEM:
  - mem_rd=1 for lw; mem_wr=1 for sw. ALU controls are held.
  - If mem_ready=1: lw goes to WB; sw asserts PCwrt=1 and goes to IF.
  - Else stay, wcnt++.
- WB:
  - RegWrite=1 and PCwrt=1, go to IF.
  - Selects: R-type RegDst=1/MemtoReg=0; ori/lui RegDst=0/MemtoReg=0; lw RegDst=0/MemtoReg=1.
- Timeout:
  - wcnt clears on entry to IF or MEM and on any ready.
  - If mem_ready=0 and wcnt==TIMEOUT-1, go to ERR.
  - If mem_ready=1 in that same cycle, ready wins.
- ERR:
  - err=1 and all strobes 0.
  - Sticky until reset.
- Retire counter: instr_cnt increments by 1 on every posedge where PCwrt=1. It wraps modulo 2^CNT_W.
- Per-instruction latency in cycles, with zero-wait memory:
  - j and jal: 2.
  - beq: 3.
  - R-type, ori, lui, sw: 4.
  - lw: 5.

Decomposition:
- Package mc_defs holds:
  - state encodings;
  - opcode and funct constants;
  - ALUop, RegDst and MemtoReg codes.
- Sub-module mc_decode: combinational opcode/funct to instruction class, static controls (ALUop, ALUSrc, ExtOp, RegDst, MemtoReg) and an illegal flag.
- mc_control holds the FSM, wcnt and instr_cnt.

Test Plan:
- Reset, then `addu` (opcode 0x00, funct 0x21), mem_ready tied 1:
  - state sequence 0, 1, 2, 4, 0;
  - RegWrite=1 with RegDst=1 only in WB;
  - PCwrt pulses once; instr_cnt=1.
- beq (opcode 0x04), zero=1, then again with zero=0:
  - zero=1: EXE shows branch=1, PCwrt=1; 3 cycles total.
  - zero=0: branch=0, PCwrt=1.
- lw (opcode 0x23), mem_ready low for 3 cycles in MEM:
  - MEM persists 4 cycles with mem_rd=1;
  - then WB with MemtoReg=1, RegWrite=1; total 8 cycles.
- jal (opcode 0x03):
  - ID shows jump=1, PCwrt=1, RegWrite=1, RegDst=2, MemtoReg=2;
  - next state IF.
- opcode 0x3f, and separately funct 0x00 with opcode 0x00:
  - goes to ERR, err=1, all strobes 0;
  - reset returns state to 0 and err to 0.
- TIMEOUT=16, mem_ready held 0 in IF:
  - 16 wait cycles, then ERR.
  - Variant: mem_ready=1 on the 16th wait cycle goes to ID.
  - Variant: reset asserted during MEM of sw gives no mem_wr or PCwrt the next cycle; state=0; instr_cnt=0.
